// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and defaults for the core/loader memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE,
    CORE_ACC,
    LDR_ACC
  } arbState_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - single-port synchronous-read memory bus
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - two-way round-robin grant with loader lock
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic reqCore,
  input  logic reqLdr,
  input  logic lock,
  input  logic advance,
  output logic grantCore,
  output logic grantLdr
);

  // Points at the loader out of reset so the core wins the first tie.
  logic lastLdr;

  always_comb begin
    grantCore = 1'b0;
    grantLdr  = 1'b0;
    if (lock) begin
      grantLdr = reqLdr;
    end else if (reqCore && reqLdr) begin
      grantCore = lastLdr;
      grantLdr  = !lastLdr;
    end else begin
      grantCore = reqCore;
      grantLdr  = reqLdr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastLdr <= 1'b1;
    end else if (advance && (grantCore || grantLdr)) begin
      lastLdr <= grantLdr;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one synchronous memory between the multicycle core and the loader
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_rd,
  input  logic        core_wr,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ready,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic [31:0] ldr_rdata,
  output logic        ldr_ack,
  input  logic        ldr_lock,
  mem_arbiter_if.master mem
);

  arbState_t state;
  logic      coreReq;
  logic      isIdle;
  logic      grantCore;
  logic      grantLdr;
  logic      selCore;
  logic      selLdr;
  logic      unusedAddrBits;

  assign coreReq = core_rd | core_wr;
  assign isIdle  = (state == IDLE) && !reset;
  assign selCore = isIdle && grantCore;
  assign selLdr  = isIdle && grantLdr;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .reqCore   (coreReq),
    .reqLdr    (ldr_req),
    .lock      (ldr_lock),
    .advance   (isIdle),
    .grantCore (grantCore),
    .grantLdr  (grantLdr)
  );

  // Word access: byte-offset bits and anything above the memory size alias away.
  assign unusedAddrBits = ^{core_addr[31:ADDR_W+2], core_addr[1:0],
                            ldr_addr[31:ADDR_W+2], ldr_addr[1:0]};

  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (selCore) begin
      mem.mem_en    = 1'b1;
      mem.mem_we    = core_wr;
      mem.mem_addr  = core_addr[ADDR_W+1:2];
      mem.mem_wdata = core_wdata;
    end else if (selLdr) begin
      mem.mem_en    = 1'b1;
      mem.mem_we    = ldr_we;
      mem.mem_addr  = ldr_addr[ADDR_W+1:2];
      mem.mem_wdata = ldr_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      core_ready <= 1'b0;
      ldr_ack    <= 1'b0;
    end else begin
      core_ready <= 1'b0;
      ldr_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (selCore) begin
            state      <= CORE_ACC;
            core_ready <= 1'b1;
          end else if (selLdr) begin
            state   <= LDR_ACC;
            ldr_ack <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign core_rdata = core_ready ? mem.mem_rdata : 32'h0;
  assign ldr_rdata  = ldr_ack    ? mem.mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_rd, core_wr, ldr_req, ldr_we, ldr_lock;
  logic [31:0] core_addr, core_wdata, ldr_addr, ldr_wdata;
  logic [31:0] core_rdata, ldr_rdata;
  logic        core_ready, ldr_ack;

  mem_arbiter_if #(.ADDR_W(AW)) memBus ();

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_rd    (core_rd),
    .core_wr    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ready (core_ready),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_rdata  (ldr_rdata),
    .ldr_ack    (ldr_ack),
    .ldr_lock   (ldr_lock),
    .mem        (memBus)
  );

  always #5 clk = ~clk;

  logic [31:0] memArr [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (memBus.mem_en) begin
      if (memBus.mem_we) memArr[memBus.mem_addr] <= memBus.mem_wdata;
      memBus.mem_rdata <= memArr[memBus.mem_addr];
    end
  end

  typedef struct {
    logic        cRd, cWr;
    logic [31:0] cAddr, cWdata;
    logic        lReq, lWe;
    logic [31:0] lAddr, lWdata;
    logic        lock;
    logic        eEn, eWe;
    logic [9:0]  eAddr;
    logic [31:0] eWdata;
    logic        eReady, eAck;
    logic [31:0] eRdata;
  } vec_t;

  vec_t vecs [13];
  int   passCnt = 0;
  int   totalCnt = 0;

  function automatic vec_t mk(logic cRd, logic cWr, logic [31:0] cAddr, logic [31:0] cWdata,
                              logic lReq, logic lWe, logic [31:0] lAddr, logic [31:0] lWdata,
                              logic lock, logic eEn, logic eWe, logic [9:0] eAddr,
                              logic [31:0] eWdata, logic eReady, logic eAck, logic [31:0] eRdata);
    vec_t v;
    v.cRd = cRd; v.cWr = cWr; v.cAddr = cAddr; v.cWdata = cWdata;
    v.lReq = lReq; v.lWe = lWe; v.lAddr = lAddr; v.lWdata = lWdata;
    v.lock = lock; v.eEn = eEn; v.eWe = eWe; v.eAddr = eAddr; v.eWdata = eWdata;
    v.eReady = eReady; v.eAck = eAck; v.eRdata = eRdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passCnt++;
  endtask

  task automatic setIn(input logic cRd, input logic cWr, input logic [31:0] cAddr,
                       input logic [31:0] cWdata, input logic lReq, input logic lWe,
                       input logic [31:0] lAddr, input logic [31:0] lWdata, input logic lock);
    core_rd = cRd; core_wr = cWr; core_addr = cAddr; core_wdata = cWdata;
    ldr_req = lReq; ldr_we = lWe; ldr_addr = lAddr; ldr_wdata = lWdata; ldr_lock = lock;
  endtask

  task automatic clearIn();
    setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) memArr[i] <= 32'h1000_0000 | i;
    memArr[4] <= 32'h00A0_0093;

    vecs[0]  = mk(0,0,32'h0,32'h0,                 0,0,32'h0,32'h0,           0, 0,0,10'h0,32'h0,         0,0,32'h0);
    vecs[1]  = mk(1,0,32'h10,32'h0,                0,0,32'h0,32'h0,           0, 1,0,10'h4,32'h0,         1,0,32'h00A0_0093);
    vecs[2]  = mk(1,0,32'h1004,32'h0,              0,0,32'h0,32'h0,           0, 1,0,10'h1,32'h0,         1,0,32'h1000_0001);
    vecs[3]  = mk(0,1,32'h20,32'hCAFE_F00D,        0,0,32'h0,32'h0,           0, 1,1,10'h8,32'hCAFE_F00D, 1,0,32'h1000_0008);
    vecs[4]  = mk(1,1,32'h24,32'h1234_5678,        0,0,32'h0,32'h0,           0, 1,1,10'h9,32'h1234_5678, 1,0,32'h1000_0009);
    vecs[5]  = mk(1,0,32'h20,32'h0,                0,0,32'h0,32'h0,           0, 1,0,10'h8,32'h0,         1,0,32'hCAFE_F00D);
    vecs[6]  = mk(0,0,32'h0,32'h0,                 1,0,32'h10,32'h0,          0, 1,0,10'h4,32'h0,         0,1,32'h00A0_0093);
    vecs[7]  = mk(0,0,32'h0,32'h0,                 1,1,32'h3FC,32'hA5A5_A5A5, 0, 1,1,10'hFF,32'hA5A5_A5A5,0,1,32'h1000_00FF);
    vecs[8]  = mk(0,0,32'h0,32'h0,                 1,0,32'h3FF,32'h0,         0, 1,0,10'hFF,32'h0,        0,1,32'hA5A5_A5A5);
    vecs[9]  = mk(1,0,32'h10,32'h0,                0,0,32'h0,32'h0,           1, 0,0,10'h0,32'h0,         0,0,32'h0);
    vecs[10] = mk(0,0,32'h0,32'h0,                 1,0,32'h24,32'h0,          1, 1,0,10'h9,32'h0,         0,1,32'h1234_5678);
    vecs[11] = mk(1,0,32'hFFFF_F010,32'h0,         0,0,32'h0,32'h0,           0, 1,0,10'h4,32'h0,         1,0,32'h00A0_0093);
    vecs[12] = mk(0,0,32'h0,32'h0,                 0,1,32'h40,32'h1,          0, 0,0,10'h0,32'h0,         0,0,32'h0);

    clearIn();
    core_rd = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_mem_en", memBus.mem_en, 0);
    chk("reset_mem_we", memBus.mem_we, 0);
    chk("reset_core_ready", core_ready, 0);
    chk("reset_ldr_ack", ldr_ack, 0);
    chk("reset_core_rdata", core_rdata, 0);
    clearIn();
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
      setIn(vecs[i].cRd, vecs[i].cWr, vecs[i].cAddr, vecs[i].cWdata,
            vecs[i].lReq, vecs[i].lWe, vecs[i].lAddr, vecs[i].lWdata, vecs[i].lock);
      #1;
      chk($sformatf("v%0d_mem_en", i), memBus.mem_en, vecs[i].eEn);
      chk($sformatf("v%0d_mem_we", i), memBus.mem_we, vecs[i].eWe);
      if (vecs[i].eEn) begin
        chk($sformatf("v%0d_mem_addr", i), memBus.mem_addr, vecs[i].eAddr);
        chk($sformatf("v%0d_mem_wdata", i), memBus.mem_wdata, vecs[i].eWdata);
      end
      @(negedge clk);
      chk($sformatf("v%0d_core_ready", i), core_ready, vecs[i].eReady);
      chk($sformatf("v%0d_ldr_ack", i), ldr_ack, vecs[i].eAck);
      chk($sformatf("v%0d_core_rdata", i), core_rdata, vecs[i].eReady ? vecs[i].eRdata : 32'h0);
      chk($sformatf("v%0d_ldr_rdata", i), ldr_rdata, vecs[i].eAck ? vecs[i].eRdata : 32'h0);
      chk($sformatf("v%0d_acc_mem_en", i), memBus.mem_en, 0);
      clearIn();
      @(negedge clk);
    end

    // Tie from reset: core first, then strict alternation with both held.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    setIn(1, 0, 32'h10, 32'h0, 1, 0, 32'h3FC, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_mem_addr", k), memBus.mem_addr, (k % 2 == 0) ? 10'h4 : 10'hFF);
      @(negedge clk);
      chk($sformatf("rr%0d_core_ready", k), core_ready, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_ldr_ack", k), ldr_ack, (k % 2 == 0) ? 0 : 1);
      chk($sformatf("rr%0d_rdata", k), (k % 2 == 0) ? core_rdata : ldr_rdata,
          (k % 2 == 0) ? 32'h00A0_0093 : 32'hA5A5_A5A5);
      @(negedge clk);
    end
    clearIn();
    @(negedge clk);

    // Lock: loader writes while core read waits until the lock drops.
    setIn(1, 0, 32'h8, 32'h0, 1, 1, 32'h8, 32'hDEAD_BEEF, 1);
    #1;
    chk("lock_grant_we", memBus.mem_we, 1);
    chk("lock_grant_addr", memBus.mem_addr, 10'h2);
    chk("lock_grant_wdata", memBus.mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("lock_ldr_ack", ldr_ack, 1);
    chk("lock_core_ready_acc", core_ready, 0);
    ldr_req = 1'b0;
    ldr_we = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("lock_wait%0d_ready", k), core_ready, 0);
      chk($sformatf("lock_wait%0d_mem_en", k), memBus.mem_en, 0);
    end
    ldr_lock = 1'b0;
    #1;
    chk("unlock_mem_en", memBus.mem_en, 1);
    chk("unlock_mem_addr", memBus.mem_addr, 10'h2);
    @(negedge clk);
    chk("unlock_core_ready", core_ready, 1);
    chk("unlock_core_rdata", core_rdata, 32'hDEAD_BEEF);
    clearIn();
    @(negedge clk);

    // Lock rising during CORE_ACC lets that access finish, then blocks the core.
    setIn(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    ldr_lock = 1'b1;
    #1;
    chk("lockrise_core_ready", core_ready, 1);
    chk("lockrise_core_rdata", core_rdata, 32'h00A0_0093);
    @(negedge clk);
    chk("lockrise_next_mem_en", memBus.mem_en, 0);
    @(negedge clk);
    chk("lockrise_next_ready", core_ready, 0);
    clearIn();
    @(negedge clk);

    // Reset mid-access kills the pulse and re-points the tie toward the core.
    setIn(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    chk("rst_acc_ready_before", core_ready, 1);
    reset = 1'b1;
    #1;
    chk("rst_acc_ready", core_ready, 0);
    chk("rst_acc_rdata", core_rdata, 0);
    setIn(1, 0, 32'h10, 32'h0, 1, 0, 32'h3FC, 32'h0, 0);
    #1;
    chk("rst_hold_mem_en", memBus.mem_en, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_tie_mem_en", memBus.mem_en, 1);
    chk("rst_tie_mem_addr", memBus.mem_addr, 10'h4);
    @(negedge clk);
    chk("rst_tie_core_ready", core_ready, 1);
    chk("rst_tie_ldr_ack", ldr_ack, 0);
    clearIn();
    @(negedge clk);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 10, memory word-address width (memory holds 2^ADDR_W 32-bit words).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 core_rd  input  1  multicycle core memory-read request (MemRead).
REQ-005 core_wr  input  1  multicycle core memory-write request (MemWrite).
REQ-006 core_addr  input  32  core byte address (IorD-selected).
REQ-007 core_wdata  input  32  core store data.
REQ-008 core_rdata  output  32  read data to core; valid only while core_ready=1.
REQ-009 core_ready  output  1  one-cycle completion pulse; the core FSM holds its state while waiting for it.
REQ-010 ldr_req  input  1  loader/debug-port request.
REQ-011 ldr_we  input  1  loader write enable (qualifies ldr_req).
REQ-012 ldr_addr  input  32  loader byte address.
REQ-013 ldr_wdata  input  32  loader write data.
REQ-014 ldr_rdata  output  32  read data to loader; valid only while ldr_ack=1.
REQ-015 ldr_ack  output  1  one-cycle loader completion pulse.
REQ-016 ldr_lock  input  1  when high, only the loader can be granted (program-load mode).
REQ-017 mem_en  output  1  memory access strobe.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_addr  output  ADDR_W  word address, taken from selected address bits [ADDR_W+1:2].
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_rdata  input  32  synchronous-read memory data, valid one cycle after mem_en.

Function
REQ-022 The FSM SHALL have three states: IDLE, CORE_ACC, LDR_ACC.
REQ-023 In IDLE, grant is decided combinationally; mem_en, mem_we, mem_addr, and mem_wdata are driven from the winner in the same cycle; the next state is CORE_ACC or LDR_ACC.
REQ-024 In CORE_ACC/LDR_ACC: core_ready/ldr_ack=1 for exactly that cycle, rdata=mem_rdata, mem_en=0, next state always IDLE.
REQ-025 Latency: request seen in IDLE at cycle N leads to a completion pulse in cycle N+1; minimum 2 cycles between grants.
REQ-026 Core request = core_rd|core_wr; if both are high, the access SHALL be a write.
REQ-027 Both requesting, ldr_lock=0: round-robin, the requester not granted last wins.
REQ-028 ldr_lock=1: core is never granted; a pending core request waits, with core_ready held at 0.
REQ-029 Requesters SHALL hold request/address/data stable until their completion pulse; the arbiter does not register request inputs.
REQ-030 Address bits [1:0] and bits above ADDR_W+1 are ignored (word access, aliasing wrap).
REQ-031 No request in IDLE: mem_en=0, mem_we=0, state remains IDLE.
REQ-032 ldr_lock rising while the core is in CORE_ACC: the current access completes normally; the lock applies from the next IDLE.
REQ-033 core_rdata/ldr_rdata SHALL read 0 whenever the matching pulse is low.

Reset
REQ-034 On reset: state=IDLE, last-grant pointer=loader (core wins the first tie), all outputs 0; this holds immediately and asynchronously, including mid-access, with the pending pulse suppressed.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum and ADDR_W default.
REQ-036 A sub-module rr_arbiter2 (2-way round-robin with lock input and last-grant register) SHALL implement REQ-027/028.

Verification
REQ-037 Core read addr 0x0000_0010, mem word 4 = 0x00A0_0093 -> mem_addr=4 in cycle N, core_ready=1 and core_rdata=0x00A0_0093 in N+1.
REQ-038 Both core and loader request from reset -> core granted first, loader next; alternate for 4 back-to-back accesses.
REQ-039 ldr_lock=1, loader writes 0xDEAD_BEEF to addr 0x8, core read pending -> core_ready stays 0 until lock drops; core then reads 0xDEAD_BEEF.
REQ-040 Core core_rd=core_wr=1 -> mem_we=1 on the grant cycle.
REQ-041 Assert reset during CORE_ACC -> core_ready=0 immediately, state IDLE, and the next tie is won by the core.
REQ-042 Core addr 0x0000_1004 with ADDR_W=10 -> mem_addr=1 (aliasing).
